// File: rtl/estufa_ctrl.sv
// Greenhouse climate controller: drives heater/cooler from two threshold sensors,
// with minimum on-time, dead time, persistence-filtered latched fault and entry counters.
module estufa_ctrl #(
    parameter int unsigned MIN_ON        = 4,
    parameter int unsigned DEAD_TIME     = 2,
    parameter int unsigned FAULT_PERSIST = 3
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] sens,
    input  logic       ack_fault,
    output logic       heater,
    output logic       cooler,
    output logic       alarm,
    output logic [2:0] state,
    output logic [7:0] heat_count,
    output logic [7:0] cool_count
);

    localparam int unsigned TW = 8;
    localparam int unsigned CW = 8;

    localparam logic [TW-1:0] MIN_LOAD   = TW'(MIN_ON - 1);
    localparam logic [TW-1:0] DEAD_LOAD  = TW'(DEAD_TIME - 1);
    localparam logic [CW-1:0] FAULT_LAST = CW'(FAULT_PERSIST - 1);

    localparam logic [1:0] CODE_COLD = 2'b00;
    localparam logic [1:0] CODE_OK   = 2'b10;
    localparam logic [1:0] CODE_HOT  = 2'b11;
    localparam logic [1:0] CODE_BAD  = 2'b01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        COOL  = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [1:0]    sync0;
    logic [1:0]    s;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [CW-1:0] fault_cnt;
    logic [CW-1:0] fault_cnt_nxt;
    logic [7:0]    heat_nxt;
    logic [7:0]    cool_nxt;
    logic          fault_hit;

    // Two-flop synchronizer; resets to the "ok" code so nothing fires out of reset
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            sync0 <= CODE_OK;
            s     <= CODE_OK;
        end else begin
            sync0 <= sens;
            s     <= sync0;
        end
    end

    // Persistence filter: counts consecutive inconsistent samples
    always_comb begin
        fault_cnt_nxt = '0;
        if (s == CODE_BAD) begin
            fault_cnt_nxt = (fault_cnt == '1) ? fault_cnt : fault_cnt + CW'(1);
        end
        fault_hit = (s == CODE_BAD) && (fault_cnt == FAULT_LAST);
    end

    // Next-state, timer and counter update
    always_comb begin
        nxt       = IDLE;
        timer_nxt = timer;
        heat_nxt  = heat_count;
        cool_nxt  = cool_count;
        case (cur)
            IDLE: begin
                if (s == CODE_COLD) begin
                    nxt       = HEAT;
                    timer_nxt = MIN_LOAD;
                    heat_nxt  = (heat_count == '1) ? heat_count : heat_count + 8'd1;
                end else if (s == CODE_HOT) begin
                    nxt       = COOL;
                    timer_nxt = MIN_LOAD;
                    cool_nxt  = (cool_count == '1) ? cool_count : cool_count + 8'd1;
                end else begin
                    nxt = IDLE;
                end
            end
            HEAT: begin
                if (timer != '0) begin
                    nxt       = HEAT;
                    timer_nxt = timer - TW'(1);
                end else if (s == CODE_COLD) begin
                    nxt = HEAT;
                end else begin
                    nxt       = DEAD;
                    timer_nxt = DEAD_LOAD;
                end
            end
            COOL: begin
                if (timer != '0) begin
                    nxt       = COOL;
                    timer_nxt = timer - TW'(1);
                end else if (s == CODE_HOT) begin
                    nxt = COOL;
                end else begin
                    nxt       = DEAD;
                    timer_nxt = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (timer == '0) begin
                    nxt = IDLE;
                end else begin
                    nxt       = DEAD;
                    timer_nxt = timer - TW'(1);
                end
            end
            FAULT: begin
                if (ack_fault && (s != CODE_BAD)) begin
                    nxt       = DEAD;
                    timer_nxt = DEAD_LOAD;
                end else begin
                    nxt = FAULT;
                end
            end
            default: nxt = IDLE;
        endcase
        // A persistent fault overrides whatever the state machine wanted this edge
        if (fault_hit) begin
            nxt       = FAULT;
            timer_nxt = timer;
            heat_nxt  = heat_count;
            cool_nxt  = cool_count;
        end
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            cur        <= IDLE;
            timer      <= '0;
            fault_cnt  <= '0;
            heat_count <= '0;
            cool_count <= '0;
            heater     <= 1'b0;
            cooler     <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            cur        <= nxt;
            timer      <= timer_nxt;
            fault_cnt  <= fault_cnt_nxt;
            heat_count <= heat_nxt;
            cool_count <= cool_nxt;
            heater     <= (nxt == HEAT);
            cooler     <= (nxt == COOL);
            alarm      <= (nxt == FAULT);
        end
    end

    assign state = cur;

endmodule
